// File: rtl/boot_pkg.sv
// Shared definitions for the UART boot loader: frame FSM states and frame constants.
package boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN0,
        ST_LEN1,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } boot_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int         HDR_LEN   = 3;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, half-bit start re-check, centre-of-bit sampling.
module uart_rx #(
    parameter int CLK_DIV = 1085
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_ferr
);
    localparam int            CW   = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t     r_state;
    logic          r_sync1, r_sync2, r_prev;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_valid, r_ferr;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            // Synchronizer clears low so a line already low at release is not taken as a start edge.
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_state <= RX_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_sync1 <= rxd;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    if (r_prev && !r_sync2) begin
                        r_state <= RX_START;
                        r_cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (r_cnt == HALF) begin
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_state <= r_sync2 ? RX_IDLE : RX_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (r_cnt == LAST) begin
                        r_cnt   <= '0;
                        r_shift <= {r_sync2, r_shift[7:1]};
                        r_bit   <= r_bit + 1'b1;
                        if (r_bit == 3'd7) r_state <= RX_STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (r_cnt == LAST) begin
                        r_cnt   <= '0;
                        r_valid <= r_sync2;
                        r_ferr  <= !r_sync2;
                        r_state <= RX_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

    assign rx_data  = r_shift;
    assign rx_valid = r_valid;
    assign rx_ferr  = r_ferr;

endmodule

// File: rtl/uart_boot_loader.sv
// Boot loader: parses SYNC/N/data/CSUM frames from the UART, writes words to program RAM,
// and releases the CPU from reset once the checksum matches.
module uart_boot_loader
    import boot_pkg::*;
#(
    parameter int         CLK_DIV = 1085,
    parameter int         ADDR_W  = 15,
    parameter int         TIMEOUT = 1 << 20,
    parameter logic [7:0] SYNC    = SYNC_BYTE
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              rxd,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_resetn,
    output logic              boot_done,
    output logic              boot_err
);
    localparam int            TW    = $clog2(TIMEOUT);
    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT - 1);

    logic [7:0] w_rx_data;
    logic       w_rx_valid, w_rx_ferr;

    uart_rx #(.CLK_DIV(CLK_DIV)) u_rx (
        .clk      (clk),
        .resetn   (resetn),
        .rxd      (rxd),
        .rx_data  (w_rx_data),
        .rx_valid (w_rx_valid),
        .rx_ferr  (w_rx_ferr)
    );

    boot_state_t       r_state;
    logic [15:0]       r_len;
    logic [16:0]       r_word_cnt;
    logic [1:0]        r_byte_idx;
    logic [23:0]       r_word;
    logic [7:0]        r_sum;
    logic [TW-1:0]     r_timer;
    logic              r_wen, r_cpu_resetn, r_done, r_err;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;

    logic [15:0] w_len;
    logic        w_len_big, w_active, w_timeout;

    assign w_len     = {w_rx_data, r_len[7:0]};
    assign w_len_big = {1'b0, w_len} > (17'd1 << ADDR_W);
    assign w_active  = (r_state == ST_LEN0) || (r_state == ST_LEN1) ||
                       (r_state == ST_DATA) || (r_state == ST_CSUM);
    assign w_timeout = (r_timer == LIMIT) && !w_rx_valid;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_len        <= '0;
            r_word_cnt   <= '0;
            r_byte_idx   <= '0;
            r_word       <= '0;
            r_sum        <= '0;
            r_timer      <= '0;
            r_wen        <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_cpu_resetn <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_wen <= 1'b0;
            if (w_active && !w_rx_valid) r_timer <= r_timer + 1'b1;
            else                         r_timer <= '0;

            case (r_state)
                ST_IDLE, ST_ERR: begin
                    if (w_rx_valid && w_rx_data == SYNC) begin
                        r_state    <= ST_LEN0;
                        r_err      <= 1'b0;
                        r_word_cnt <= '0;
                        r_byte_idx <= '0;
                        r_sum      <= '0;
                    end
                end
                ST_LEN0: begin
                    if (w_rx_valid) begin
                        r_len[7:0] <= w_rx_data;
                        r_state    <= ST_LEN1;
                    end
                end
                ST_LEN1: begin
                    if (w_rx_valid) begin
                        r_len[15:8] <= w_rx_data;
                        if (w_len_big) begin
                            r_state <= ST_ERR;
                            r_err   <= 1'b1;
                        end else if (w_len == 16'd0) begin
                            r_state <= ST_CSUM;
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_rx_valid) begin
                        r_sum      <= r_sum + w_rx_data;
                        r_word     <= {w_rx_data, r_word[23:8]};
                        r_byte_idx <= r_byte_idx + 1'b1;
                        // Fourth byte completes the little-endian word.
                        if (r_byte_idx == 2'd3) begin
                            r_wen      <= 1'b1;
                            r_addr     <= r_word_cnt[ADDR_W-1:0];
                            r_wdata    <= {w_rx_data, r_word};
                            r_word_cnt <= r_word_cnt + 1'b1;
                            if (r_word_cnt + 17'd1 == {1'b0, r_len}) r_state <= ST_CSUM;
                        end
                    end
                end
                ST_CSUM: begin
                    if (w_rx_valid) begin
                        if (w_rx_data == r_sum) begin
                            r_state      <= ST_DONE;
                            r_done       <= 1'b1;
                            r_cpu_resetn <= 1'b1;
                        end else begin
                            r_state <= ST_ERR;
                            r_err   <= 1'b1;
                        end
                    end
                end
                ST_DONE: ;
                default: r_state <= ST_IDLE;
            endcase

            if (w_active && (w_rx_ferr || w_timeout)) begin
                r_state <= ST_ERR;
                r_err   <= 1'b1;
            end
        end
    end

    assign mem_wen    = r_wen;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign cpu_resetn = r_cpu_resetn;
    assign boot_done  = r_done;
    assign boot_err   = r_err;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader with a fast UART (CLK_DIV=8) and a 16-word RAM.
module tb_uart_boot_loader;
    import boot_pkg::*;

    localparam int CLK_DIV = 8;
    localparam int ADDR_W  = 4;
    localparam int TIMEOUT = 200;

    typedef logic [7:0] bq_t[$];

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              rxd = 1'b1;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_resetn, boot_done, boot_err;

    int errors = 0;
    int checks = 0;

    logic [ADDR_W-1:0] wr_addr[$];
    logic [31:0]       wr_data[$];
    logic              prev_wen = 1'b0;

    always #5 clk = ~clk;

    uart_boot_loader #(
        .CLK_DIV (CLK_DIV),
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT),
        .SYNC    (SYNC_BYTE)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .rxd        (rxd),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_resetn (cpu_resetn),
        .boot_done  (boot_done),
        .boot_err   (boot_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // RAM-side monitor: logs every write and checks the strobe is a single cycle.
    always @(negedge clk) begin
        if (mem_wen) begin
            $display("write addr=%0d data=%08h", mem_addr, mem_wdata);
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
            check("wen_one_cycle", 32'(prev_wen), 32'd0);
        end
        prev_wen = mem_wen;
    end

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_out(input logic v);
        rxd = v;
        repeat (CLK_DIV) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(b[i]);
        bit_out(stop_bit);
    endtask

    task automatic send_bytes(input bq_t q);
        foreach (q[i]) send_byte(q[i], 1'b1);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        wr_addr.delete();
        wr_data.delete();
        idle(4);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_wen"},   32'(mem_wen),    32'd0);
        check({tag, "_addr"},  32'(mem_addr),   32'd0);
        check({tag, "_wdata"}, mem_wdata,       32'd0);
        check({tag, "_cpurn"}, 32'(cpu_resetn), 32'd0);
        check({tag, "_done"},  32'(boot_done),  32'd0);
        check({tag, "_err"},   32'(boot_err),   32'd0);
    endtask

    initial begin
        bq_t good_body, garbage, hdr_big, empty_img, big_img, head6, img2;
        logic [7:0] sum16;
        logic [7:0] d;

        good_body = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                      8'hEF, 8'hBE, 8'hAD, 8'hDE};
        garbage   = '{8'h00, 8'hFF, 8'h3C};
        hdr_big   = '{8'hA5, 8'h11, 8'h00};
        empty_img = '{8'hA5, 8'h00, 8'h00, 8'h00};
        head6     = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE};
        img2      = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA};

        @(negedge clk);
        do_reset();
        check_reset_vals("reset");

        // Garbage and a short glitch in IDLE, then the good image.
        send_bytes(garbage);
        rxd = 1'b0;
        repeat (2) @(negedge clk);
        idle(30);
        check("garbage_writes", 32'(wr_addr.size()), 32'd0);
        check("garbage_err", 32'(boot_err), 32'd0);
        send_bytes(good_body);
        idle(2);
        check("pre_csum_done", 32'(boot_done), 32'd0);
        send_byte(8'h4C, 1'b1);
        idle(2);
        $display("frame good: header %0d bytes, writes %0d", HDR_LEN, wr_addr.size());
        check("good_writes", 32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) begin
            check("good_addr0", 32'(wr_addr[0]), 32'd0);
            check("good_data0", wr_data[0], 32'h12345678);
            check("good_addr1", 32'(wr_addr[1]), 32'd1);
            check("good_data1", wr_data[1], 32'hDEADBEEF);
        end
        check("good_done", 32'(boot_done), 32'd1);
        check("good_cpurn", 32'(cpu_resetn), 32'd1);
        check("good_err", 32'(boot_err), 32'd0);

        // Bad checksum, then recovery on the next SYNC.
        do_reset();
        send_bytes(good_body);
        send_byte(8'h4D, 1'b1);
        idle(2);
        $display("frame bad csum: err=%0b", boot_err);
        check("badcs_err", 32'(boot_err), 32'd1);
        check("badcs_cpurn", 32'(cpu_resetn), 32'd0);
        check("badcs_done", 32'(boot_done), 32'd0);
        send_byte(8'hA5, 1'b1);
        idle(2);
        check("resync_err_clr", 32'(boot_err), 32'd0);
        for (int i = 1; i < good_body.size(); i++) send_byte(good_body[i], 1'b1);
        send_byte(8'h4C, 1'b1);
        idle(2);
        $display("frame resend: done=%0b", boot_done);
        check("resend_done", 32'(boot_done), 32'd1);
        check("resend_cpurn", 32'(cpu_resetn), 32'd1);

        // N=17 exceeds the 16-word RAM.
        do_reset();
        send_bytes(hdr_big);
        idle(2);
        $display("frame N=17: err=%0b", boot_err);
        check("big_n_err", 32'(boot_err), 32'd1);
        check("big_n_writes", 32'(wr_addr.size()), 32'd0);

        // N=0 goes straight to the checksum byte.
        do_reset();
        send_bytes(empty_img);
        idle(2);
        $display("frame N=0: done=%0b", boot_done);
        check("empty_done", 32'(boot_done), 32'd1);
        check("empty_writes", 32'(wr_addr.size()), 32'd0);

        // Full RAM image: 16 words.
        do_reset();
        big_img = '{8'hA5, 8'h10, 8'h00};
        sum16 = 8'h00;
        for (int w = 0; w < 16; w++) begin
            for (int k = 0; k < 4; k++) begin
                d = 8'(w * 4 + k + 16);
                big_img.push_back(d);
                sum16 = sum16 + d;
            end
        end
        big_img.push_back(sum16);
        send_bytes(big_img);
        idle(2);
        $display("frame N=16: writes %0d done=%0b", wr_addr.size(), boot_done);
        check("full_writes", 32'(wr_addr.size()), 32'd16);
        if (wr_addr.size() == 16) begin
            for (int w = 0; w < 16; w++) begin
                check("full_addr", 32'(wr_addr[w]), 32'(w));
                check("full_data", wr_data[w],
                      {8'(w*4+19), 8'(w*4+18), 8'(w*4+17), 8'(w*4+16)});
            end
        end
        check("full_done", 32'(boot_done), 32'd1);

        // Framing error in DATA.
        do_reset();
        send_bytes('{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56});
        send_byte(8'h34, 1'b0);
        idle(12);
        $display("frame ferr: err=%0b", boot_err);
        check("ferr_err", 32'(boot_err), 32'd1);
        check("ferr_done", 32'(boot_done), 32'd0);

        // Stall after the sixth data byte.
        do_reset();
        send_bytes(head6);
        idle(250);
        $display("frame stall: err=%0b", boot_err);
        check("timeout_err", 32'(boot_err), 32'd1);
        check("timeout_cpurn", 32'(cpu_resetn), 32'd0);

        // Reset mid-DATA, then a fresh frame loads from address 0.
        do_reset();
        send_bytes('{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF});
        check("middata_wr", 32'(wr_addr.size()), 32'd1);
        do_reset();
        check_reset_vals("midrst");
        send_bytes(img2);
        idle(2);
        $display("frame after reset: writes %0d done=%0b", wr_addr.size(), boot_done);
        check("rst_writes", 32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() == 1) begin
            check("rst_addr", 32'(wr_addr[0]), 32'd0);
            check("rst_data", wr_data[0], 32'h44332211);
        end
        check("rst_done", 32'(boot_done), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
